// File: rtl/alu_display_pkg.sv
// Shared seven-segment glyphs and hex decoder for the ALU status display.
// Every code is active-low with bit order g..a.
package alu_display_pkg;

    typedef logic [6:0] seg7_t;

    localparam seg7_t GLYPH_BLANK = 7'b1111111;
    localparam seg7_t GLYPH_C     = 7'b1000110;
    localparam seg7_t GLYPH_MINUS = 7'b0111111;
    localparam seg7_t GLYPH_E     = 7'b0000110;

    function automatic seg7_t hex_to_seg7(input logic [3:0] nib);
        seg7_t s;
        s = GLYPH_BLANK;
        case (nib)
            4'h0: s = 7'b1000000;
            4'h1: s = 7'b1111001;
            4'h2: s = 7'b0100100;
            4'h3: s = 7'b0110000;
            4'h4: s = 7'b0011001;
            4'h5: s = 7'b0010010;
            4'h6: s = 7'b0000010;
            4'h7: s = 7'b1111000;
            4'h8: s = 7'b0000000;
            4'h9: s = 7'b0010000;
            4'hA: s = 7'b0001000;
            4'hB: s = 7'b0000011;
            4'hC: s = 7'b1000110;
            4'hD: s = 7'b0100001;
            4'hE: s = 7'b0000110;
            4'hF: s = 7'b0001110;
        endcase
        return s;
    endfunction

endpackage

// File: rtl/display_scan_timer.sv
// Refresh prescaler, scanned digit index and carry-blink phase generator.
// One digit slot lasts REFRESH_DIV cycles; the blink phase flips every BLINK_TICKS slots.
module display_scan_timer #(
    parameter int DIGITS      = 4,
    parameter int REFRESH_DIV = 50000,
    parameter int BLINK_TICKS = 64
) (
    input  logic                      clk,
    input  logic                      rst,
    output logic [$clog2(DIGITS)-1:0] index_o,
    output logic                      blink_phase_o
);
    localparam int PW = $clog2(REFRESH_DIV);
    localparam int BW = (BLINK_TICKS > 1) ? $clog2(BLINK_TICKS) : 1;
    localparam int IW = $clog2(DIGITS);

    logic [PW-1:0] presc_q, presc_d;
    logic [IW-1:0] idx_q, idx_d;
    logic [BW-1:0] bcnt_q, bcnt_d;
    logic          phase_q, phase_d;
    logic          tick;

    assign tick = (presc_q == PW'(REFRESH_DIV - 1));

    always_comb begin
        presc_d = tick ? '0 : presc_q + 1'b1;
        idx_d   = idx_q;
        bcnt_d  = bcnt_q;
        phase_d = phase_q;
        if (tick) begin
            idx_d = (idx_q == IW'(DIGITS - 1)) ? '0 : idx_q + 1'b1;
            // With BLINK_TICKS=1 the counter sits at 0 and the phase flips every slot.
            if (bcnt_q == BW'(BLINK_TICKS - 1)) begin
                bcnt_d  = '0;
                phase_d = ~phase_q;
            end else begin
                bcnt_d = bcnt_q + 1'b1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            presc_q <= '0;
            idx_q   <= '0;
            bcnt_q  <= '0;
            phase_q <= 1'b0;
        end else begin
            presc_q <= presc_d;
            idx_q   <= idx_d;
            bcnt_q  <= bcnt_d;
            phase_q <= phase_d;
        end
    end

    assign index_o       = idx_q;
    assign blink_phase_o = phase_q;

endmodule

// File: rtl/alu_status_display.sv
// Multiplexed seven-segment driver: digit 0 shows the C/N/Z flag glyph,
// digits 1..DIGITS-1 show the latched result in hex with optional leading-zero blanking.
module alu_status_display
    import alu_display_pkg::*;
#(
    parameter int DIGITS      = 4,
    parameter int WIDTH       = 12,
    parameter int REFRESH_DIV = 50000,
    parameter int BLINK_TICKS = 64,
    parameter int LZB         = 1
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              valid_i,
    input  logic [2:0]        flags_C_N_Z,
    input  logic [WIDTH-1:0]  result,
    input  logic              blink_en,
    output logic [6:0]        displays,
    output logic [DIGITS-1:0] an_o
);
    localparam int IW = $clog2(DIGITS);

    logic [WIDTH-1:0]  res_q;
    logic [2:0]        flg_q;
    seg7_t             disp_q, disp_d;
    logic [DIGITS-1:0] an_q, an_d;
    logic [IW-1:0]     idx;
    logic              blink_phase;

    display_scan_timer #(
        .DIGITS     (DIGITS),
        .REFRESH_DIV(REFRESH_DIV),
        .BLINK_TICKS(BLINK_TICKS)
    ) u_timer (
        .clk          (clk),
        .rst          (rst),
        .index_o      (idx),
        .blink_phase_o(blink_phase)
    );

    always_comb begin
        seg7_t      glyph;
        logic [3:0] nib;
        logic       lz;
        glyph = GLYPH_BLANK;
        if (flg_q[2])      glyph = GLYPH_C;
        else if (flg_q[1]) glyph = GLYPH_MINUS;
        else if (flg_q[0]) glyph = GLYPH_E;
        if (blink_en && flg_q[2] && blink_phase) glyph = GLYPH_BLANK;

        // A digit above 1 is blank only when it and every higher nibble are zero.
        nib = '0;
        lz  = 1'b0;
        for (int k = 1; k < DIGITS; k++) begin
            if (idx == IW'(k)) begin
                nib = res_q[4*(k-1) +: 4];
                lz  = (LZB != 0) && (k >= 2) && ((res_q >> (4*(k-1))) == '0);
            end
        end

        disp_d = (idx == '0) ? glyph : (lz ? GLYPH_BLANK : hex_to_seg7(nib));
        an_d   = '1;
        an_d[idx] = 1'b0;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            res_q  <= '0;
            flg_q  <= '0;
            disp_q <= GLYPH_BLANK;
            an_q   <= '1;
        end else begin
            if (valid_i) begin
                res_q <= result;
                flg_q <= flags_C_N_Z;
            end
            disp_q <= disp_d;
            an_q   <= an_d;
        end
    end

    assign displays = disp_q;
    assign an_o     = an_q;

endmodule

// File: tb/tb_alu_status_display.sv
// Directed bench: a cycle-count reference model queues the expected pins for each edge,
// plus spot checks of literal segment codes. A second instance uses BLINK_TICKS=3 so blinking is visible on digit 0.
module tb_alu_status_display;
    localparam int RD = 4;
    localparam int ND = 4;

    typedef struct {
        logic [6:0] da;
        logic [6:0] db;
        logic [3:0] an;
    } exp_t;

    localparam logic [6:0] HEX [16] = '{7'b1000000, 7'b1111001, 7'b0100100, 7'b0110000,
                                        7'b0011001, 7'b0010010, 7'b0000010, 7'b1111000,
                                        7'b0000000, 7'b0010000, 7'b0001000, 7'b0000011,
                                        7'b1000110, 7'b0100001, 7'b0000110, 7'b0001110};

    logic        clk = 1'b0;
    logic        rst, valid_i, blink_en;
    logic [2:0]  flags;
    logic [11:0] result;
    logic [6:0]  disp_a, disp_b;
    logic [3:0]  an_a, an_b;

    exp_t        q[$];
    int          n_cmp = 0;
    int          n_bad = 0;
    int          cyc = 0;
    int          blinks_seen = 0;
    logic [11:0] m_res = '0;
    logic [2:0]  m_flg = '0;
    string       tag = "reset";

    always #5 clk = ~clk;

    alu_status_display #(.DIGITS(4), .WIDTH(12), .REFRESH_DIV(4), .BLINK_TICKS(2), .LZB(1)) dut (
        .clk(clk), .rst(rst), .valid_i(valid_i), .flags_C_N_Z(flags), .result(result),
        .blink_en(blink_en), .displays(disp_a), .an_o(an_a));

    alu_status_display #(.DIGITS(4), .WIDTH(12), .REFRESH_DIV(4), .BLINK_TICKS(3), .LZB(1)) dut_b (
        .clk(clk), .rst(rst), .valid_i(valid_i), .flags_C_N_Z(flags), .result(result),
        .blink_en(blink_en), .displays(disp_b), .an_o(an_b));

    // Expected pins after the next edge, from the count of non-reset edges since reset.
    task automatic model(input int bt, output logic [6:0] seg, output logic [3:0] an);
        int idx;
        logic [3:0] nib;
        idx = (cyc / RD) % ND;
        an = 4'hF;
        an[idx] = 1'b0;
        if (idx == 0) begin
            if (m_flg[2])      seg = 7'b1000110;
            else if (m_flg[1]) seg = 7'b0111111;
            else if (m_flg[0]) seg = 7'b0000110;
            else               seg = 7'b1111111;
            if (blink_en && m_flg[2] && ((cyc / (RD * bt)) % 2 == 1)) seg = 7'b1111111;
        end else begin
            nib = m_res[4*(idx-1) +: 4];
            if (idx >= 2 && (m_res >> (4*(idx-1))) == 12'h000) seg = 7'b1111111;
            else seg = HEX[nib];
        end
    endtask

    task automatic step();
        exp_t e;
        logic [3:0] an2;
        if (rst) begin
            e.da = 7'h7F; e.db = 7'h7F; e.an = 4'hF;
        end else begin
            model(2, e.da, e.an);
            model(3, e.db, an2);
        end
        q.push_back(e);
        @(posedge clk);
        if (rst) begin
            cyc = 0; m_res = '0; m_flg = '0;
        end else begin
            cyc++;
            if (valid_i) begin m_res = result; m_flg = flags; end
        end
        #1;
        e = q.pop_front();
        n_cmp++;
        assert (disp_a === e.da) else begin n_bad++; $error("FAIL %s displays got %b exp %b", tag, disp_a, e.da); end
        n_cmp++;
        assert (an_a === e.an) else begin n_bad++; $error("FAIL %s an_o got %b exp %b", tag, an_a, e.an); end
        n_cmp++;
        assert (disp_b === e.db) else begin n_bad++; $error("FAIL %s displays_b got %b exp %b", tag, disp_b, e.db); end
        n_cmp++;
        assert (an_b === e.an) else begin n_bad++; $error("FAIL %s an_o_b got %b exp %b", tag, an_b, e.an); end
        if (!rst && an_b == 4'b1110 && disp_b == 7'h7F && m_flg[2]) blinks_seen++;
    endtask

    task automatic run_to(input logic [3:0] an_t, input logic [6:0] seg_t, input string name);
        int k;
        k = 0;
        while (an_a !== an_t && k < 20) begin step(); k++; end
        n_cmp++;
        assert (an_a === an_t && disp_a === seg_t) else begin
            n_bad++;
            $error("FAIL %s an=%b seg=%b exp an=%b seg=%b", name, an_a, disp_a, an_t, seg_t);
        end
    endtask

    initial begin
        rst = 1'b1; valid_i = 1'b0; flags = 3'b000; result = 12'h000; blink_en = 1'b0;
        repeat (3) step();
        rst = 1'b0;
        tag = "scan";
        step();
        n_cmp++;
        assert (an_a === 4'b1110 && disp_a === 7'h7F) else begin
            n_bad++; $error("FAIL first_slot an=%b seg=%b exp an=1110 seg=1111111", an_a, disp_a);
        end
        repeat (70) step();

        tag = "hex";
        valid_i = 1'b1; result = 12'hA08; flags = 3'b000;
        step();
        valid_i = 1'b0;
        repeat (2) step();
        run_to(4'b0111, 7'b0001000, "hex_d3");
        run_to(4'b1011, 7'b1000000, "hex_d2");
        run_to(4'b1101, 7'b0000000, "hex_d1");
        repeat (16) step();

        tag = "lzb";
        valid_i = 1'b1; result = 12'h005; flags = 3'b001;
        step();
        valid_i = 1'b0;
        repeat (2) step();
        run_to(4'b0111, 7'b1111111, "lzb_d3");
        run_to(4'b1011, 7'b1111111, "lzb_d2");
        run_to(4'b1101, 7'b0010010, "lzb_d1");
        run_to(4'b1110, 7'b0000110, "glyph_E");
        repeat (16) step();

        tag = "blink";
        valid_i = 1'b1; flags = 3'b110; blink_en = 1'b1;
        step();
        valid_i = 1'b0;
        blinks_seen = 0;
        repeat (64) step();
        n_cmp++;
        assert (blinks_seen > 0) else begin n_bad++; $error("FAIL blink_seen got %0d exp >0", blinks_seen); end
        tag = "steady";
        blink_en = 1'b0;
        blinks_seen = 0;
        repeat (48) step();
        n_cmp++;
        assert (blinks_seen == 0) else begin n_bad++; $error("FAIL steady_blanks got %0d exp 0", blinks_seen); end
        run_to(4'b1110, 7'b1000110, "steady_C");

        tag = "collide";
        valid_i = 1'b1; result = 12'h111; flags = 3'b000;
        step();
        valid_i = 1'b0;
        repeat (20) step();
        while (cyc % RD != RD - 1) step();
        valid_i = 1'b1; result = 12'hFFF;
        step();
        valid_i = 1'b0;
        repeat (2) step();
        run_to(4'b0111, 7'b0001110, "collide_d3");
        run_to(4'b1011, 7'b0001110, "collide_d2");
        run_to(4'b1101, 7'b0001110, "collide_d1");
        repeat (8) step();

        tag = "midrst";
        while ((cyc / RD) % ND != 2) step();
        step();
        rst = 1'b1;
        step();
        n_cmp++;
        assert (an_a === 4'b1111 && disp_a === 7'h7F) else begin
            n_bad++; $error("FAIL midrst_blank an=%b seg=%b exp an=1111 seg=1111111", an_a, disp_a);
        end
        rst = 1'b0;
        step();
        n_cmp++;
        assert (an_a === 4'b1110 && disp_a === 7'h7F) else begin
            n_bad++; $error("FAIL midrst_restart an=%b seg=%b exp an=1110 seg=1111111", an_a, disp_a);
        end
        run_to(4'b1101, 7'b1000000, "midrst_zero");
        repeat (20) step();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
